// File: rtl/cia_tod_ctrl_pkg.sv
// cia_tod_ctrl_pkg: shared types and default thresholds
// for the TOD mains-frequency controller.
package cia_tod_ctrl_pkg;

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        C50     = 2'd1,
        C60     = 2'd2
    } tod_class_t;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tod_fsm_t;

    localparam int unsigned DEF_P50_MIN    = 18000;
    localparam int unsigned DEF_P50_MAX    = 22000;
    localparam int unsigned DEF_P60_MIN    = 15000;
    localparam int unsigned DEF_LOCK_CNT   = 4;
    localparam int unsigned DEF_GEN_HALF50 = 9852;
    localparam int unsigned DEF_GEN_HALF60 = 8523;
    localparam int unsigned DEF_TMO_CNT    = 65534;

    function automatic tod_class_t classify(
        input logic [16:0] p,
        input logic [16:0] p50_min,
        input logic [16:0] p50_max,
        input logic [16:0] p60_min
    );
        tod_class_t c;
        c = INVALID;
        if (p >= p50_min && p <= p50_max)
            c = C50;
        else if (p >= p60_min && p < p50_min)
            c = C60;
        return c;
    endfunction

endpackage

// File: rtl/cia_tod_ctrl_if.sv
// cia_tod_ctrl_if: pad/register side bundle of the
// TOD frequency controller.
interface cia_tod_ctrl_if;
    logic        phi2_dn;
    logic        tod_pad;
    logic        cra_todin;
    logic        auto_en;
    logic        gen_en;
    logic        tod;
    logic        tod50hz;
    logic        locked;
    logic [15:0] period;

    modport master (
        output phi2_dn, tod_pad, cra_todin,
        output auto_en, gen_en,
        input  tod, tod50hz, locked, period
    );

    modport slave (
        input  phi2_dn, tod_pad, cra_todin,
        input  auto_en, gen_en,
        output tod, tod50hz, locked, period
    );
endinterface

// File: rtl/cia_edgedet.sv
// cia_edgedet: rising-edge detector sampled on an
// enable strobe.
module cia_edgedet (
    input  logic clk,
    input  logic res,
    input  logic i_en,
    input  logic i_d,
    output logic o_rise
);
    logic r_prev;

    always_ff @(posedge clk) begin
        if (res)
            r_prev <= 1'b0;
        else if (i_en)
            r_prev <= i_d;
    end

    assign o_rise = i_en & i_d & ~r_prev;
endmodule

// File: rtl/cia_tod_gen.sv
// cia_tod_gen: internal 50/60 Hz square wave for
// boards without a mains TOD line.
module cia_tod_gen #(
    parameter int unsigned HALF50 = 9852,
    parameter int unsigned HALF60 = 8523
) (
    input  logic clk,
    input  logic res,
    input  logic i_phi2_dn,
    input  logic i_en,
    input  logic i_sel50,
    output logic o_q
);
    localparam logic [15:0] L_R50 = 16'(HALF50 - 1);
    localparam logic [15:0] L_R60 = 16'(HALF60 - 1);

    logic [15:0] r_cnt;
    logic        r_q;
    logic [15:0] w_reload;

    assign w_reload = i_sel50 ? L_R50 : L_R60;

    // Idle keeps the counter at reload so enabling
    // yields a full first half-period.
    always_ff @(posedge clk) begin
        if (res || !i_en) begin
            r_cnt <= w_reload;
            r_q   <= 1'b0;
        end else if (i_phi2_dn) begin
            if (r_cnt == 16'd0) begin
                r_cnt <= w_reload;
                r_q   <= ~r_q;
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/cia_tod_ctrl.sv
// cia_tod_ctrl: measures the TOD period, locks onto
// 50/60 Hz and drives the tod50hz select.
module cia_tod_ctrl
    import cia_tod_ctrl_pkg::*;
#(
    parameter int unsigned P50_MIN    = DEF_P50_MIN,
    parameter int unsigned P50_MAX    = DEF_P50_MAX,
    parameter int unsigned P60_MIN    = DEF_P60_MIN,
    parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
    parameter int unsigned GEN_HALF50 = DEF_GEN_HALF50,
    parameter int unsigned GEN_HALF60 = DEF_GEN_HALF60,
    parameter int unsigned TMO_CNT    = DEF_TMO_CNT
) (
    input logic           clk,
    input logic           res,
    cia_tod_ctrl_if.slave bus
);
    localparam logic [16:0] L_P50_MIN = 17'(P50_MIN);
    localparam logic [16:0] L_P50_MAX = 17'(P50_MAX);
    localparam logic [16:0] L_P60_MIN = 17'(P60_MIN);
    localparam logic [15:0] L_TMO     = 16'(TMO_CNT);
    localparam logic [2:0]  L_LOCK    = 3'(LOCK_CNT);

    logic        r_sync1, r_sync2;
    logic        r_gen_en_d, r_armed;
    logic [15:0] r_cnt, r_period;
    tod_fsm_t    r_state, w_state_nxt;
    tod_class_t  r_cand, w_cand_nxt, w_cls;
    logic [2:0]  r_streak, w_streak_nxt;
    logic [2:0]  r_miss, w_miss_nxt;
    logic        r_det50, w_det50_nxt;

    logic        w_gen_q, w_src, w_rise, w_gen_tgl;
    logic [16:0] w_p17, w_pc;
    logic [15:0] w_p;
    logic        w_tmo, w_edge_cls, w_cls_v;
    logic [2:0]  w_inc, w_miss_inc;
    logic        w_match, w_locked;

    cia_tod_gen #(
        .HALF50 (GEN_HALF50),
        .HALF60 (GEN_HALF60)
    ) u_gen (
        .clk       (clk),
        .res       (res),
        .i_phi2_dn (bus.phi2_dn),
        .i_en      (bus.gen_en),
        .i_sel50   (bus.cra_todin),
        .o_q       (w_gen_q)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_gen_en_d <= 1'b0;
        end else begin
            r_sync1    <= bus.tod_pad;
            r_sync2    <= r_sync1;
            r_gen_en_d <= bus.gen_en;
        end
    end

    assign w_src     = bus.gen_en ? w_gen_q : r_sync2;
    assign w_gen_tgl = bus.gen_en ^ r_gen_en_d;

    cia_edgedet u_edge (
        .clk    (clk),
        .res    (res),
        .i_en   (bus.phi2_dn),
        .i_d    (w_src),
        .o_rise (w_rise)
    );

    assign w_p17      = {1'b0, r_cnt} + 17'd1;
    assign w_p        = w_p17[16] ? 16'hFFFF : w_p17[15:0];
    assign w_pc       = {1'b0, w_p};
    assign w_tmo      = bus.phi2_dn & ~w_rise
                      & (r_cnt == L_TMO);
    // A source switch restarts measurement: the next
    // edge only opens a fresh period.
    assign w_edge_cls = w_rise & r_armed & ~w_gen_tgl;
    assign w_cls_v    = w_edge_cls | w_tmo;
    assign w_cls      = w_tmo ? INVALID :
        classify(w_pc, L_P50_MIN, L_P50_MAX, L_P60_MIN);

    always_ff @(posedge clk) begin
        if (res) begin
            r_cnt    <= 16'd0;
            r_period <= 16'd0;
            r_armed  <= 1'b0;
        end else begin
            if (bus.phi2_dn) begin
                if (w_rise || w_tmo)
                    r_cnt <= 16'd0;
                else
                    r_cnt <= r_cnt + 16'd1;
            end
            if (w_edge_cls)
                r_period <= w_p;
            if (w_gen_tgl)
                r_armed <= 1'b0;
            else if (w_rise)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res)
            r_state <= SEARCH;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_cand   <= INVALID;
            r_streak <= 3'd0;
            r_miss   <= 3'd0;
            r_det50  <= 1'b0;
        end else begin
            r_cand   <= w_cand_nxt;
            r_streak <= w_streak_nxt;
            r_miss   <= w_miss_nxt;
            r_det50  <= w_det50_nxt;
        end
    end

    assign w_inc      = (w_cls == r_cand) ?
                        r_streak + 3'd1 : 3'd1;
    assign w_miss_inc = r_miss + 3'd1;
    assign w_match    = (w_cls == C50 &&  r_det50)
                      | (w_cls == C60 && !r_det50);

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_streak_nxt = r_streak;
        w_miss_nxt   = r_miss;
        w_det50_nxt  = r_det50;
        if (w_cls_v) begin
            unique case (r_state)
                SEARCH: begin
                    if (w_cls == INVALID) begin
                        w_streak_nxt = 3'd0;
                    end else begin
                        w_cand_nxt   = w_cls;
                        w_streak_nxt = w_inc;
                        if (w_inc == L_LOCK) begin
                            w_state_nxt = LOCKED;
                            w_det50_nxt = (w_cls == C50);
                            w_miss_nxt  = 3'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_miss_nxt = 3'd0;
                    end else if (w_miss_inc == L_LOCK) begin
                        w_state_nxt  = SEARCH;
                        w_streak_nxt = 3'd0;
                        w_miss_nxt   = 3'd0;
                    end else begin
                        w_miss_nxt = w_miss_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_locked    = (r_state == LOCKED);
        bus.locked  = w_locked;
        bus.tod50hz = (bus.auto_en & w_locked) ?
                      r_det50 : bus.cra_todin;
        bus.tod     = w_src;
        bus.period  = r_period;
    end
endmodule

// File: tb/tb_cia_tod_ctrl.sv
// tb_cia_tod_ctrl: directed bench for the TOD frequency
// controller, run with scaled-down period thresholds.
module tb_cia_tod_ctrl;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    cia_tod_ctrl_if bus();

    cia_tod_ctrl #(
        .P50_MIN    (180),
        .P50_MAX    (220),
        .P60_MIN    (150),
        .LOCK_CNT   (4),
        .GEN_HALF50 (98),
        .GEN_HALF60 (85),
        .TMO_CNT    (999)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.phi2_dn = 1'b0;
        forever begin
            @(negedge clk);
            bus.phi2_dn = ~bus.phi2_dn;
        end
    end

    typedef struct {
        int   per;
        logic lk;
        logic t50;
    } cls_vec_t;

    typedef struct {
        logic au;
        logic cr;
        logic t50;
    } mux_vec_t;

    cls_vec_t cv[6];
    mux_vec_t mv[4];

    task automatic chk(input string nm,
                       input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d",
                     nm, act, exp);
        end
    endtask

    task automatic wait_strobes(input int n);
        repeat (n) begin
            do @(posedge clk); while (!bus.phi2_dn);
        end
        #1;
    endtask

    task automatic pad_run(input int per, input int n);
        repeat (n) begin
            bus.tod_pad = 1'b1;
            wait_strobes(per / 2);
            bus.tod_pad = 1'b0;
            wait_strobes(per - per / 2);
        end
    endtask

    task automatic do_reset();
        bus.tod_pad = 1'b0;
        bus.gen_en  = 1'b0;
        res = 1'b1;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
    endtask

    task automatic half_per(output int n);
        logic prev;
        prev = bus.tod;
        n = 0;
        do begin
            wait_strobes(1);
            n++;
        end while (bus.tod == prev && n < 2000);
    endtask

    initial begin
        int h;
        cv[0] = '{149, 1'b0, 1'b0};
        cv[1] = '{150, 1'b1, 1'b0};
        cv[2] = '{179, 1'b1, 1'b0};
        cv[3] = '{180, 1'b1, 1'b1};
        cv[4] = '{220, 1'b1, 1'b1};
        cv[5] = '{221, 1'b0, 1'b0};
        mv[0] = '{1'b0, 1'b0, 1'b0};
        mv[1] = '{1'b0, 1'b1, 1'b1};
        mv[2] = '{1'b1, 1'b0, 1'b1};
        mv[3] = '{1'b1, 1'b1, 1'b1};

        bus.tod_pad   = 1'b0;
        bus.cra_todin = 1'b1;
        bus.auto_en   = 1'b1;
        bus.gen_en    = 1'b0;
        do_reset();
        chk("rst_locked", bus.locked, 0);
        chk("rst_period", bus.period, 0);
        chk("rst_tod", bus.tod, 0);
        chk("rst_t50", bus.tod50hz, 1);

        // 50 Hz lock
        bus.cra_todin = 1'b0;
        pad_run(197, 4);
        chk("p50_4edges_locked", bus.locked, 0);
        pad_run(197, 1);
        chk("p50_locked", bus.locked, 1);
        chk("p50_period", bus.period, 197);
        chk("p50_t50", bus.tod50hz, 1);
        for (int i = 0; i < 4; i++) begin
            bus.auto_en   = mv[i].au;
            bus.cra_todin = mv[i].cr;
            #1;
            chk($sformatf("mux%0d", i),
                bus.tod50hz, mv[i].t50);
        end
        bus.auto_en   = 1'b1;
        bus.cra_todin = 1'b0;

        // 50 -> 60 -> 50
        pad_run(164, 4);
        chk("sw60_3miss_locked", bus.locked, 1);
        pad_run(164, 1);
        chk("sw60_unlock", bus.locked, 0);
        chk("sw60_period", bus.period, 164);
        chk("sw60_t50_cra", bus.tod50hz, 0);
        pad_run(164, 3);
        chk("sw60_3agree", bus.locked, 0);
        pad_run(164, 1);
        bus.cra_todin = 1'b1;
        #1;
        chk("sw60_relock", bus.locked, 1);
        chk("sw60_det60", bus.tod50hz, 0);
        bus.cra_todin = 1'b0;
        pad_run(197, 5);
        chk("sw50_unlock", bus.locked, 0);
        pad_run(197, 4);
        chk("sw50_relock", bus.locked, 1);
        chk("sw50_det50", bus.tod50hz, 1);

        // pad stuck low: timeout every 1000 strobes
        wait_strobes(2303);
        chk("tmo2_locked", bus.locked, 1);
        wait_strobes(1000);
        chk("tmo3_locked", bus.locked, 1);
        wait_strobes(1000);
        chk("tmo4_unlock", bus.locked, 0);
        chk("tmo4_t50", bus.tod50hz, 0);
        chk("tmo_period", bus.period, 197);

        // alternating valid/invalid
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pad_run(200, 1);
            pad_run(300, 1);
        end
        chk("alt_locked", bus.locked, 0);
        chk("alt_period", bus.period, 200);

        // classification boundaries
        for (int i = 0; i < 6; i++) begin
            do_reset();
            bus.auto_en   = 1'b1;
            bus.cra_todin = 1'b0;
            pad_run(cv[i].per, 5);
            chk($sformatf("cls%0d_locked", cv[i].per),
                bus.locked, cv[i].lk);
            chk($sformatf("cls%0d_t50", cv[i].per),
                bus.tod50hz, cv[i].t50);
            chk($sformatf("cls%0d_period", cv[i].per),
                bus.period, cv[i].per);
        end

        // internal generator
        do_reset();
        bus.cra_todin = 1'b1;
        bus.auto_en   = 1'b1;
        wait_strobes(2);
        bus.gen_en = 1'b1;
        wait_strobes(830);
        chk("gen_4rise_locked", bus.locked, 0);
        wait_strobes(170);
        chk("gen_locked", bus.locked, 1);
        chk("gen_period", bus.period, 196);
        bus.cra_todin = 1'b0;
        #1;
        chk("gen_det50", bus.tod50hz, 1);
        bus.cra_todin = 1'b1;
        half_per(h);
        half_per(h);
        chk("gen_half50_a", h, 98);
        half_per(h);
        chk("gen_half50_b", h, 98);
        bus.gen_en = 1'b0;
        wait_strobes(1);
        chk("gen_off_tod", bus.tod, 0);
        bus.cra_todin = 1'b0;
        wait_strobes(2);
        bus.gen_en = 1'b1;
        half_per(h);
        half_per(h);
        chk("gen_half60", h, 85);
        bus.gen_en = 1'b0;

        // reset mid-period while locked
        do_reset();
        bus.cra_todin = 1'b0;
        pad_run(197, 5);
        chk("mid_pre_locked", bus.locked, 1);
        bus.tod_pad = 1'b1;
        wait_strobes(50);
        chk("mid_pre_tod", bus.tod, 1);
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_locked", bus.locked, 0);
        chk("mid_period", bus.period, 0);
        chk("mid_tod", bus.tod, 0);
        res = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
